crc32_frame_checker: RTL and testbench
======================================

// Module: crc32_frame_checker
// PURPOSE
//  Receive-side companion to the bit-serial CRC32 generator. Takes a serial frame
//  (payload bits then 32 appended CRC bits, MSB-first), recomputes CRC32 across the
//  whole frame and flags pass/fail at end-of-frame. Sits after the serial link and
//  before frame consumers. Keeps frame/error statistics for debug.
// PARAMETERS
//  POLY      32'h04C11DB7  CRC polynomial, non-reflected, MSB-first
//  CRC_INIT  32'h00000000  LFSR value loaded at start of each frame
//  CNT_W     16            width of bit_count, frame_cnt, err_cnt
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      asynchronous reset, active-low (0 = reset)
//  data_in    in   1      serial bit, valid only when enable=1
//  enable     in   1      bit qualifier; cycles with enable=0 are ignored
//  sof        in   1      first bit of frame; sampled only when enable=1
//  eof        in   1      last bit of frame; sampled only when enable=1
//  busy       out  1      frame in progress (state RECV)
//  done       out  1      1-cycle pulse: frame result valid
//  crc_ok     out  1      last frame passed (held until next sof)
//  crc_err    out  1      last frame failed CRC (held until next sof)
//  len_err    out  1      last frame shorter than 33 bits (held until next sof)
//  rx_crc     out  32     last 32 bits of last frame (received CRC field)
//  bit_count  out  CNT_W  accepted bits in current/last frame, saturating
//  frame_cnt  out  CNT_W  completed frames since reset, saturating
//  err_cnt    out  CNT_W  frames with crc_err or len_err, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, LFSR=CRC_INIT, all outputs 0.
//  - LFSR step per accepted bit b: fb=lfsr[31]^b; lfsr={lfsr[30:0],1'b0}^(fb?POLY:0).
//    Frame correct iff LFSR==0 after all bits incl. CRC field (no final XOR, no reflection).
//  - Window shift reg: win={win[30:0],data_in} on every accepted bit in a frame.
//  - FSM IDLE: enable&sof -> load LFSR=CRC_INIT, step with this bit, bit_count=1,
//    clear crc_ok/crc_err/len_err, go RECV. enable&!sof ignored (eof alone ignored).
//  - RECV: each enable=1 bit steps LFSR, bit_count+1 (saturates at all-ones).
//    enable&eof: bit is included, then go IDLE and next cycle: done=1, rx_crc=win,
//    len_err=(bit_count<33), crc_err=!len_err&(LFSR!=0), crc_ok=!len_err&(LFSR==0),
//    frame_cnt+1, err_cnt+1 if len_err|crc_err (both saturate, never wrap).
//  - sof&eof same bit: 1-bit frame -> len_err, done as above.
//  - sof in RECV (without eof): current frame aborted silently (no done, no counters),
//    restart with this bit as first bit. sof&eof in RECV: abort, then 1-bit frame.
//  - Latency: done/status registered, 1 cycle after the eof bit is sampled.
//  - done is never asserted two cycles in a row; busy=0 in the done cycle.
//  - Reset asserted mid-frame: frame discarded, counters cleared, no done.
// TESTING
//  1. Frame 8'hAB + 32'hDA649D6F (40 bits MSB-first, eof on bit 40) -> done 1 cycle
//     later, crc_ok=1, crc_err=0, rx_crc=32'hDA649D6F, bit_count=40, frame_cnt=1.
//  2. Same frame, bit 3 flipped -> crc_err=1, crc_ok=0, err_cnt=1, frame_cnt=1.
//  3. Same frame with random enable=0 gaps of 1-5 cycles -> identical to case 1.
//  4. 16-bit frame 16'hABCD -> len_err=1, crc_ok=0, crc_err=0, err_cnt+1.
//  5. sof after 20 bits then full case-1 frame -> one done only, crc_ok=1, frame_cnt+1.
//  6. rst=0 after 10 bits of a frame -> all outputs 0 immediately, no done; case 1
//     afterwards passes; CNT_W=2, 5 good frames -> frame_cnt holds 3.

Source files
------------

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC32 frame checker. A serial frame (payload followed by its 32-bit CRC,
// MSB-first) is run through the same LFSR as the generator. A correct frame leaves the
// LFSR at zero. The result is reported one cycle after the eof bit, and frame and error
// statistics are kept for debug.
module crc32_frame_checker #(
  parameter logic [31:0] POLY     = 32'h04C11DB7,
  parameter logic [31:0] CRC_INIT = 32'h00000000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             enable,
  input  logic             sof,
  input  logic             eof,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [31:0]      rx_crc,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  // Frames shorter than this cannot hold a payload bit plus the CRC field.
  localparam logic [5:0]       MinLen = 6'd33;

  // One MSB-first LFSR step for a single received bit.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b);
    logic fb;
    fb = crc[31] ^ b;
    return {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      win_q, win_d;
  logic [31:0]      rx_crc_q, rx_crc_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  // Length tracked independently of bit_count, so the length check still works when
  // CNT_W is too narrow to count to 33. It saturates at MinLen.
  logic [5:0]       len_q, len_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             crc_err_q, crc_err_d;
  logic             len_err_q, len_err_d;

  logic             start_bit;
  logic             cont_bit;
  logic             frame_end;
  logic             short_frame;

  // Classify the current input bit: a frame start, a continuation, or ignored.
  // A 1-bit frame arriving in the done cycle is dropped, because it would produce a
  // second done pulse on the next cycle.
  always_comb begin
    start_bit = 1'b0;
    cont_bit  = 1'b0;
    if (enable) begin
      if (state_q == StRecv) begin
        start_bit = sof;
        cont_bit  = ~sof;
      end else begin
        start_bit = sof & ~(eof & done_q);
      end
    end
    frame_end = (start_bit | cont_bit) & eof;
  end

  // Next-state logic for the FSM, the datapath, the status flags and the counters.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    win_d       = win_q;
    rx_crc_d    = rx_crc_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    len_d       = len_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    short_frame = 1'b0;

    if (start_bit) begin
      // Also covers a restart from StRecv; the aborted frame leaves no trace.
      state_d   = StRecv;
      lfsr_d    = crc_step(CRC_INIT, data_in);
      win_d     = {31'h0, data_in};
      bit_cnt_d = CntOne;
      len_d     = 6'd1;
      ok_d      = 1'b0;
      crc_err_d = 1'b0;
      len_err_d = 1'b0;
    end else if (cont_bit) begin
      lfsr_d    = crc_step(lfsr_q, data_in);
      win_d     = {win_q[30:0], data_in};
      bit_cnt_d = (bit_cnt_q == CntMax) ? bit_cnt_q : bit_cnt_q + CntOne;
      len_d     = (len_q == MinLen) ? len_q : len_q + 6'd1;
    end

    if (frame_end) begin
      state_d     = StIdle;
      done_d      = 1'b1;
      short_frame = (len_d < MinLen);
      len_err_d   = short_frame;
      crc_err_d   = ~short_frame & (lfsr_d != 32'h0);
      ok_d        = ~short_frame & (lfsr_d == 32'h0);
      rx_crc_d    = win_d;
      frame_cnt_d = (frame_cnt_q == CntMax) ? frame_cnt_q : frame_cnt_q + CntOne;
      if (short_frame || (lfsr_d != 32'h0)) begin
        err_cnt_d = (err_cnt_q == CntMax) ? err_cnt_q : err_cnt_q + CntOne;
      end
    end
  end

  // State and datapath registers. The asynchronous reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      lfsr_q      <= CRC_INIT;
      win_q       <= 32'h0;
      rx_crc_q    <= 32'h0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      len_q       <= 6'd0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      win_q       <= win_d;
      rx_crc_q    <= rx_crc_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      len_q       <= len_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
    end
  end

  // Drive the outputs from the registers.
  always_comb begin
    busy      = (state_q == StRecv);
    done      = done_q;
    crc_ok    = ok_q;
    crc_err   = crc_err_q;
    len_err   = len_err_q;
    rx_crc    = rx_crc_q;
    bit_count = bit_cnt_q;
    frame_cnt = frame_cnt_q;
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Bench for crc32_frame_checker: a frame-level model (a bit queue plus polynomial
// division) predicts every output. Each cycle, the outputs are compared against the
// model for a 16-bit-counter instance and for a 2-bit-counter instance. Literal checks
// pin the known CRC vector.
module tb_crc32_frame_checker;

  localparam logic [31:0] Poly = 32'h04C11DB7;

  logic clk, rst, data_in, enable, sof, eof;
  logic        busy, done, crc_ok, crc_err, len_err;
  logic [31:0] rx_crc;
  logic [15:0] bit_count, frame_cnt, err_cnt;
  logic        s_busy, s_done, s_crc_ok, s_crc_err, s_len_err;
  logic [31:0] s_rx_crc;
  logic [1:0]  s_bit_count, s_frame_cnt, s_err_cnt;

  crc32_frame_checker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .enable(enable), .sof(sof), .eof(eof),
    .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err),
    .rx_crc(rx_crc), .bit_count(bit_count), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  crc32_frame_checker #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .data_in(data_in), .enable(enable), .sof(sof), .eof(eof),
    .busy(s_busy), .done(s_done), .crc_ok(s_crc_ok), .crc_err(s_crc_err),
    .len_err(s_len_err), .rx_crc(s_rx_crc), .bit_count(s_bit_count),
    .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Frame-level model ----------------
  bit          frame[$];
  bit          in_frame;
  bit          m_done, m_ok, m_crc_err, m_len_err;
  logic [31:0] m_rx;
  int          m_frames, m_errs;

  // The frame is valid iff its bit polynomial is divisible by the generator (init 0).
  function automatic bit frame_good();
    logic [32:0] rem;
    rem = '0;
    foreach (frame[i]) begin
      rem = {rem[31:0], frame[i]};
      if (rem[32]) rem = rem ^ {1'b1, Poly};
    end
    return rem[31:0] == 32'h0;
  endfunction

  function automatic logic [31:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit acc;
    acc = 0;
    if (!rst) begin
      frame.delete();
      in_frame = 0; m_done = 0; m_ok = 0; m_crc_err = 0; m_len_err = 0;
      m_rx = '0; m_frames = 0; m_errs = 0;
    end else begin
      if (enable) begin
        if (sof && !(!in_frame && eof && m_done)) begin
          frame.delete();
          in_frame = 1; m_ok = 0; m_crc_err = 0; m_len_err = 0;
          acc = 1;
        end else if (in_frame) begin
          acc = 1;
        end
        if (acc) frame.push_back(data_in);
      end
      m_done = 0;
      if (acc && eof) begin
        int len;
        bit good;
        len       = frame.size();
        good      = frame_good();
        m_len_err = len < 33;
        m_crc_err = !m_len_err && !good;
        m_ok      = !m_len_err && good;
        m_rx      = '0;
        for (int i = (len > 32 ? len - 32 : 0); i < len; i++) m_rx = {m_rx[30:0], frame[i]};
        m_frames++;
        if (m_len_err || m_crc_err) m_errs++;
        m_done   = 1;
        in_frame = 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", busy, in_frame);
      check("done", done, m_done);
      check("crc_ok", crc_ok, m_ok);
      check("crc_err", crc_err, m_crc_err);
      check("len_err", len_err, m_len_err);
      check("rx_crc", rx_crc, m_rx);
      check("bit_count", bit_count, sat(frame.size(), 16));
      check("frame_cnt", frame_cnt, sat(m_frames, 16));
      check("err_cnt", err_cnt, sat(m_errs, 16));
      check("s_done", s_done, m_done);
      check("s_crc_ok", s_crc_ok, m_ok);
      check("s_len_err", s_len_err, m_len_err);
      check("s_bit_count", s_bit_count, sat(frame.size(), 2));
      check("s_frame_cnt", s_frame_cnt, sat(m_frames, 2));
      check("s_err_cnt", s_err_cnt, sat(m_errs, 2));
    end
  end

  // ---------------- Stimulus ----------------
  task automatic drive(input logic en, input logic d, input logic s, input logic e);
    @(negedge clk);
    enable = en; data_in = d; sof = s; eof = e;
  endtask

  // Gap cycles carry sof/eof high to confirm that they are qualified by enable.
  task automatic gap(input int n);
    repeat (n) drive(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic send(input logic [63:0] v, input int n, input bit with_eof,
                      input int flip, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = v[n-1-i];
      if (i == flip) b = ~b;
      if (gaps && i > 0 && $urandom_range(0, 1) == 1) gap($urandom_range(1, 5));
      drive(1'b1, b, i == 0, with_eof && (i == n - 1));
    end
  endtask

  localparam logic [63:0] Good = 64'h000000ABDA649D6F;

  initial begin
    rst = 1'b0; enable = 1'b0; data_in = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    check("reset_done", done, 1'b0);
    check("reset_frame_cnt", frame_cnt, 16'h0);
    rst = 1'b1;
    drive(0, 0, 0, 0);

    // Case 1: good frame.
    send(Good, 40, 1, -1, 0);
    drive(0, 0, 0, 0);
    check("c1_done", done, 1'b1);
    check("c1_crc_ok", crc_ok, 1'b1);
    check("c1_crc_err", crc_err, 1'b0);
    check("c1_rx_crc", rx_crc, 32'hDA649D6F);
    check("c1_bit_count", bit_count, 16'd40);
    check("c1_frame_cnt", frame_cnt, 16'd1);
    check("c1_busy", busy, 1'b0);
    drive(0, 0, 0, 0);
    check("c1_done_once", done, 1'b0);

    // Case 2: third bit flipped.
    send(Good, 40, 1, 2, 0);
    drive(0, 0, 0, 0);
    check("c2_crc_err", crc_err, 1'b1);
    check("c2_crc_ok", crc_ok, 1'b0);
    check("c2_err_cnt", err_cnt, 16'd1);
    check("c2_frame_cnt", frame_cnt, 16'd2);
    gap(2);

    // Case 3: good frame with enable gaps.
    send(Good, 40, 1, -1, 1);
    drive(0, 0, 0, 0);
    check("c3_crc_ok", crc_ok, 1'b1);
    check("c3_rx_crc", rx_crc, 32'hDA649D6F);
    check("c3_bit_count", bit_count, 16'd40);
    check("c3_frame_cnt", frame_cnt, 16'd3);
    drive(0, 0, 0, 0);

    // Case 4: short frame.
    send(64'hABCD, 16, 1, -1, 0);
    drive(0, 0, 0, 0);
    check("c4_len_err", len_err, 1'b1);
    check("c4_crc_ok", crc_ok, 1'b0);
    check("c4_crc_err", crc_err, 1'b0);
    check("c4_err_cnt", err_cnt, 16'd2);
    check("c4_bit_count", bit_count, 16'd16);
    drive(0, 0, 0, 0);

    // Case 5: abort after 20 bits by a fresh sof, then a good frame.
    send(Good, 20, 0, -1, 0);
    send(Good, 40, 1, -1, 0);
    drive(0, 0, 0, 0);
    check("c5_crc_ok", crc_ok, 1'b1);
    check("c5_frame_cnt", frame_cnt, 16'd5);
    drive(0, 0, 0, 0);

    // 1-bit frame: sof and eof on the same bit.
    drive(1, 1, 1, 1);
    drive(0, 0, 0, 0);
    check("c1bit_len_err", len_err, 1'b1);
    check("c1bit_bit_count", bit_count, 16'd1);
    check("c1bit_err_cnt", err_cnt, 16'd3);
    drive(0, 0, 0, 0);

    // Case 6: reset mid-frame.
    send(Good, 10, 0, -1, 0);
    drive(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("c6_busy", busy, 1'b0);
    check("c6_bit_count", bit_count, 16'd0);
    check("c6_frame_cnt", frame_cnt, 16'd0);
    check("c6_err_cnt", err_cnt, 16'd0);
    check("c6_crc_ok", crc_ok, 1'b0);
    check("c6_len_err", len_err, 1'b0);
    check("c6_rx_crc", rx_crc, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      send(Good, 40, 1, -1, 0);
      drive(0, 0, 0, 0);
      check("c6_frame_ok", crc_ok, 1'b1);
      drive(0, 0, 0, 0);
    end
    check("c6_frame_cnt16", frame_cnt, 16'd5);
    check("c6_frame_cnt2", s_frame_cnt, 2'd3);
    check("c6_bit_count2", s_bit_count, 2'd3);
    drive(0, 0, 0, 0);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
